// File: rtl/cm151_demux_capture.sv
// Serial-bit demultiplexer: routes din_pad into one of eight bit registers and
// captures the full byte once every index has been written since the last word.
module cm151_demux_capture #(
  parameter logic DATA_INV = 1'b0
) (
  input  logic       clk_pad,
  input  logic       rstn_pad,
  input  logic       strobe_n_pad,
  input  logic       din_pad,
  input  logic [2:0] sel_pad,
  input  logic       auto_pad,
  input  logic       clr_pad,
  input  logic       ready_pad,
  output logic [7:0] bits_pad,
  output logic [7:0] word_pad,
  output logic       word_valid_pad,
  output logic [7:0] mask_pad,
  output logic [2:0] cnt_pad,
  output logic       ovf_pad
);

  // Handshake: word_pad/word_valid_pad form a valid/ready source. A word moves
  // on any edge where valid and ready are both 1; while valid is 1 and ready is
  // 0 word_pad holds still, and a newer completed word is dropped (ovf_pad set).

  logic [7:0] bits_q, word_q, mask_q;
  logic [2:0] cnt_q;
  logic       valid_q, ovf_q;

  logic       d;
  logic [2:0] idx;
  logic       wr;
  logic [7:0] bits_nxt;
  logic [7:0] mask_wr;
  logic       complete;
  logic       xfer;

  always_comb begin
    d        = din_pad ^ DATA_INV;
    idx      = auto_pad ? cnt_q : sel_pad;
    wr       = !strobe_n_pad && !clr_pad;
    bits_nxt = bits_q;
    bits_nxt[idx] = d;
    mask_wr  = mask_q | (8'b1 << idx);
    // A rewrite of an already-marked index leaves mask_wr short of all ones.
    complete = wr && (mask_wr == 8'hFF);
    xfer     = valid_q && ready_pad;
  end

  always_ff @(posedge clk_pad or negedge rstn_pad) begin
    if (!rstn_pad) begin
      bits_q  <= 8'h00;
      word_q  <= 8'h00;
      mask_q  <= 8'h00;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr_pad) begin
      // Clear restarts the word but keeps the data registers for inspection.
      mask_q  <= 8'h00;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr) begin
        bits_q <= bits_nxt;
        mask_q <= complete ? 8'h00 : mask_wr;
        if (auto_pad) cnt_q <= cnt_q + 3'd1;
      end
      if (complete && (!valid_q || ready_pad)) begin
        word_q  <= bits_nxt;
        valid_q <= 1'b1;
      end else if (complete) begin
        ovf_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bits_pad       = bits_q;
  assign word_pad       = word_q;
  assign word_valid_pad = valid_q;
  assign mask_pad       = mask_q;
  assign cnt_pad        = cnt_q;
  assign ovf_pad        = ovf_q;

endmodule

// File: tb/tb_cm151_demux_capture.sv
// Bench for cm151_demux_capture: directed scenarios with a word scoreboard,
// one plain-data instance and one inverted-data instance on shared inputs.
module tb_cm151_demux_capture;

  logic       clk_pad = 1'b0;
  logic       rstn_pad = 1'b1;
  logic       strobe_n_pad = 1'b1;
  logic       din_pad = 1'b0;
  logic [2:0] sel_pad = 3'd0;
  logic       auto_pad = 1'b0;
  logic       clr_pad = 1'b0;
  logic       ready_pad = 1'b0;

  logic [7:0] bits0, word0, mask0, bits1, word1, mask1;
  logic [2:0] cnt0, cnt1;
  logic       valid0, ovf0, valid1, ovf1;

  logic [7:0] exp_q[$];
  logic [7:0] exp;
  int n_cmp = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk_pad = ~clk_pad;

  cm151_demux_capture #(.DATA_INV(1'b0)) dut0 (
    .clk_pad(clk_pad), .rstn_pad(rstn_pad), .strobe_n_pad(strobe_n_pad),
    .din_pad(din_pad), .sel_pad(sel_pad), .auto_pad(auto_pad), .clr_pad(clr_pad),
    .ready_pad(ready_pad), .bits_pad(bits0), .word_pad(word0),
    .word_valid_pad(valid0), .mask_pad(mask0), .cnt_pad(cnt0), .ovf_pad(ovf0));

  cm151_demux_capture #(.DATA_INV(1'b1)) dut1 (
    .clk_pad(clk_pad), .rstn_pad(rstn_pad), .strobe_n_pad(strobe_n_pad),
    .din_pad(din_pad), .sel_pad(sel_pad), .auto_pad(auto_pad), .clr_pad(clr_pad),
    .ready_pad(ready_pad), .bits_pad(bits1), .word_pad(word1),
    .word_valid_pad(valid1), .mask_pad(mask1), .cnt_pad(cnt1), .ovf_pad(ovf1));

  // driver tasks
  task automatic step();
    @(posedge clk_pad);
    #1;
  endtask

  task automatic wr(input logic d, input logic [2:0] s, input logic a);
    strobe_n_pad = 1'b0;
    din_pad      = d;
    sel_pad      = s;
    auto_pad     = a;
    step();
    strobe_n_pad = 1'b1;
  endtask

  task automatic idle();
    strobe_n_pad = 1'b1;
    din_pad      = 1'($urandom_range(0, 1));
    sel_pad      = 3'($urandom_range(0, 7));
    step();
  endtask

  task automatic pop_exp();
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    else exp = 'x;
  endtask

  task automatic test_reset();
    #1 rstn_pad = 1'b0;
    #1;
    n_cmp++; if (bits0 !== 8'h00) begin n_fail++; $display("FAIL reset_bits: got %h want 00", bits0); end
    n_cmp++; if (word0 !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h want 00", word0); end
    n_cmp++; if (mask0 !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", mask0); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    // writes while in reset must be ignored
    strobe_n_pad = 1'b0; din_pad = 1'b1; auto_pad = 1'b1;
    step();
    n_cmp++; if (bits0 !== 8'h00) begin n_fail++; $display("FAIL reset_ignore_bits: got %h want 00", bits0); end
    n_cmp++; if (mask0 !== 8'h00) begin n_fail++; $display("FAIL reset_ignore_mask: got %h want 00", mask0); end
    strobe_n_pad = 1'b1;
    rstn_pad = 1'b1;
    idle();
    idle();
  endtask

  task automatic test_auto_word();
    logic [7:0] pat;
    pat = 8'h4D;
    ready_pad = 1'b1;
    exp_q.push_back(8'h4D);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (cnt0 !== 3'(i)) begin n_fail++; $display("FAIL auto_cnt: got %0d want %0d", cnt0, i); end
      wr(pat[i], 3'($urandom_range(0, 7)), 1'b1);
      if (i == 2) begin
        n_cmp++; if (mask0 !== 8'h07) begin n_fail++; $display("FAIL auto_mask_partial: got %h want 07", mask0); end
      end
    end
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL auto_valid: got %b want 1", valid0); end
    n_cmp++; if (word0 !== exp) begin n_fail++; $display("FAIL auto_word: got %h want %h", word0, exp); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL auto_cnt_wrap: got %0d want 0", cnt0); end
    n_cmp++; if (mask0 !== 8'h00) begin n_fail++; $display("FAIL auto_mask_clear: got %h want 00", mask0); end
    n_cmp++; if (bits0 !== 8'h4D) begin n_fail++; $display("FAIL auto_bits_kept: got %h want 4d", bits0); end
    idle();
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL auto_valid_drop: got %b want 0", valid0); end
  endtask

  task automatic test_manual_hold();
    ready_pad = 1'b0;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) wr(1'b1, 3'(7 - i), 1'b0);
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL man_valid: got %b want 1", valid0); end
    n_cmp++; if (word0 !== exp) begin n_fail++; $display("FAIL man_word: got %h want %h", word0, exp); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL man_cnt_static: got %0d want 0", cnt0); end
    for (int k = 0; k < 3; k++) begin
      idle();
      n_cmp++; if (word0 !== 8'hFF || valid0 !== 1'b1) begin
        n_fail++; $display("FAIL man_hold: got word %h valid %b want ff 1", word0, valid0);
      end
    end
    // second word while the first is still pending is dropped
    for (int i = 0; i < 8; i++) wr(1'b0, 3'(i), 1'b0);
    n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL man_ovf: got %b want 1", ovf0); end
    n_cmp++; if (word0 !== 8'hFF) begin n_fail++; $display("FAIL man_word_kept: got %h want ff", word0); end
    n_cmp++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL man_valid_kept: got %b want 1", valid0); end
    n_cmp++; if (bits0 !== 8'h00) begin n_fail++; $display("FAIL man_bits_live: got %h want 00", bits0); end
    idle();
    n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL man_ovf_sticky: got %b want 1", ovf0); end
    clr_pad = 1'b1;
    idle();
    clr_pad = 1'b0;
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", valid0); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", ovf0); end
    n_cmp++; if (word0 !== 8'hFF) begin n_fail++; $display("FAIL clr_word_kept: got %h want ff", word0); end
  endtask

  task automatic test_repeat();
    logic [2:0] ix [0:6];
    logic [6:0] dv;
    ix = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    dv = 7'b0011010;  // bit j is the data for ix[j]
    ready_pad = 1'b1;
    wr(1'b1, 3'd3, 1'b0);
    wr(1'b0, 3'd3, 1'b0);
    wr(1'b1, 3'd3, 1'b0);
    n_cmp++; if (mask0 !== 8'h08) begin n_fail++; $display("FAIL rep_mask: got %h want 08", mask0); end
    n_cmp++; if (bits0 !== 8'h08) begin n_fail++; $display("FAIL rep_bits: got %h want 08", bits0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rep_no_word: got %b want 0", valid0); end
    idle();
    n_cmp++; if (bits0 !== 8'h08 || mask0 !== 8'h08) begin
      n_fail++; $display("FAIL rep_idle_hold: got bits %h mask %h want 08 08", bits0, mask0);
    end
    exp_q.push_back(8'h3A);
    for (int j = 0; j < 7; j++) begin
      wr(dv[j], ix[j], 1'b0);
      if (j < 6) begin
        n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rep_early: write %0d got valid %b want 0", j + 4, valid0); end
      end
    end
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL rep_valid: got %b want 1", valid0); end
    n_cmp++; if (word0 !== exp) begin n_fail++; $display("FAIL rep_word: got %h want %h", word0, exp); end
    idle();
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rep_drop: got %b want 0", valid0); end
  endtask

  task automatic test_back_to_back();
    ready_pad = 1'b0;
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 8; i++) wr(i[0], 3'd0, 1'b1);
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1 || word0 !== exp) begin
      n_fail++; $display("FAIL b2b_first: got word %h valid %b want %h 1", word0, valid0, exp);
    end
    exp_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) ready_pad = 1'b1;
      wr(~i[0], 3'd0, 1'b1);
    end
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", valid0); end
    n_cmp++; if (word0 !== exp) begin n_fail++; $display("FAIL b2b_word: got %h want %h", word0, exp); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", ovf0); end
    idle();
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_drop: got %b want 0", valid0); end
  endtask

  task automatic test_async_reset();
    logic [7:0] pat;
    pat = 8'h33;
    ready_pad = 1'b1;
    for (int i = 0; i < 5; i++) wr(1'b1, 3'd0, 1'b1);
    n_cmp++; if (cnt0 !== 3'd5 || mask0 !== 8'h1F) begin
      n_fail++; $display("FAIL ar_partial: got cnt %0d mask %h want 5 1f", cnt0, mask0);
    end
    #1 rstn_pad = 1'b0;
    #1;
    n_cmp++; if (bits0 !== 8'h00 || word0 !== 8'h00 || mask0 !== 8'h00) begin
      n_fail++; $display("FAIL ar_regs: got bits %h word %h mask %h want 00 00 00", bits0, word0, mask0);
    end
    n_cmp++; if (cnt0 !== 3'd0 || valid0 !== 1'b0 || ovf0 !== 1'b0) begin
      n_fail++; $display("FAIL ar_flags: got cnt %0d valid %b ovf %b want 0 0 0", cnt0, valid0, ovf0);
    end
    strobe_n_pad = 1'b0; din_pad = 1'b1; auto_pad = 1'b1;
    step();
    strobe_n_pad = 1'b1;
    rstn_pad = 1'b1;
    exp_q.push_back(8'h33);
    for (int i = 0; i < 8; i++) begin
      wr(pat[i], 3'd0, 1'b1);
      if (i < 7) begin
        n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL ar_early: write %0d got valid %b want 0", i, valid0); end
      end
    end
    pop_exp();
    n_cmp++; if (valid0 !== 1'b1 || word0 !== exp) begin
      n_fail++; $display("FAIL ar_word: got word %h valid %b want %h 1", word0, valid0, exp);
    end
    n_cmp++; if (cnt0 !== 3'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", cnt0); end
    idle();
  endtask

  task automatic test_inv();
    ready_pad = 1'b1;
    clr_pad = 1'b1;
    idle();
    clr_pad = 1'b0;
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) wr(1'b0, 3'd0, 1'b1);
    pop_exp();
    n_cmp++; if (valid1 !== 1'b1) begin n_fail++; $display("FAIL inv_valid: got %b want 1", valid1); end
    n_cmp++; if (word1 !== exp) begin n_fail++; $display("FAIL inv_word: got %h want %h", word1, exp); end
    idle();
    for (int i = 0; i < 7; i++) wr(1'b0, 3'd0, 1'b1);
    n_cmp++; if (mask1 !== 8'h7F || cnt1 !== 3'd7) begin
      n_fail++; $display("FAIL inv_partial: got mask %h cnt %0d want 7f 7", mask1, cnt1);
    end
    clr_pad = 1'b1;
    wr(1'b0, 3'd0, 1'b1);
    clr_pad = 1'b0;
    n_cmp++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL inv_clr_valid: got %b want 0", valid1); end
    n_cmp++; if (mask1 !== 8'h00 || cnt1 !== 3'd0) begin
      n_fail++; $display("FAIL inv_clr_state: got mask %h cnt %0d want 00 0", mask1, cnt1);
    end
    n_cmp++; if (word1 !== 8'hFF || bits1 !== 8'hFF) begin
      n_fail++; $display("FAIL inv_clr_kept: got word %h bits %h want ff ff", word1, bits1);
    end
    idle();
    n_cmp++; if (valid1 !== 1'b0) begin n_fail++; $display("FAIL inv_no_late: got %b want 0", valid1); end
  endtask

  initial begin
    test_reset();
    test_auto_word();
    test_manual_hold();
    test_repeat();
    test_back_to_back();
    test_async_reset();
    test_inv();
    n_cmp++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d queued want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cm151_demux_capture.md
CM151_DEMUX_CAPTURE -- requirements
Module: cm151_demux_capture

Interface
REQ-001 Parameter DATA_INV, default 0: when 1, din_pad is inverted before capture.
REQ-002 clk_pad  input  1  single clock; all state updates on rising edge.
REQ-003 rstn_pad  input  1  reset, asynchronous, active-low.
REQ-004 strobe_n_pad  input  1  active-low write enable; 1 = no write this cycle.
REQ-005 din_pad  input  1  serial data bit to route.
REQ-006 sel_pad  input  3  direct destination index in manual mode; bit0 = LSB.
REQ-007 auto_pad  input  1  1 = use internal index counter and ignore sel_pad; 0 = use sel_pad.
REQ-008 clr_pad  input  1  synchronous clear of capture state.
REQ-009 ready_pad  input  1  consumer accepts word_pad when word_valid_pad = 1.
REQ-010 bits_pad  output  8  live demultiplexed bit registers.
REQ-011 word_pad  output  8  captured complete word.
REQ-012 word_valid_pad  output  1  word_pad holds an unconsumed word.
REQ-013 mask_pad  output  8  bit i = 1 if index i has been written since the last completion or clear.
REQ-014 cnt_pad  output  3  current auto-mode index.
REQ-015 ovf_pad  output  1  sticky overflow flag.

Function
REQ-016 Effective bit d = din_pad XOR DATA_INV; effective index idx = auto_pad ? cnt : sel_pad.
REQ-017 On a write cycle (strobe_n_pad = 0, clr_pad = 0), bits[idx] <= d and mask[idx] <= 1; all other bits are unchanged; the result is visible on bits_pad the next cycle.
REQ-018 When strobe_n_pad = 1, bits, mask and cnt hold their values.
REQ-019 On a write cycle with auto_pad = 1, cnt increments modulo 8 (7 -> 0); cnt is not changed in manual mode or on non-write cycles.
REQ-020 A repeated write to an already-masked index overwrites the bit and does not count as a completion.
REQ-021 Completion occurs on a write cycle in which the mask, including the current write, becomes all ones.
REQ-022 On completion, the candidate word is bits with the current write merged in, and the mask clears to 0 on the next edge; bits_pad retains its values.
REQ-023 Handshake: a word transfers on a cycle where word_valid_pad = 1 and ready_pad = 1; word_pad is stable while word_valid_pad = 1 and ready_pad = 0.
REQ-024 On completion with word_valid_pad = 0, or with word_valid_pad = 1 and ready_pad = 1 in the same cycle: word_pad <= candidate and word_valid_pad = 1 next cycle (latency 1 from the 8th write).
REQ-025 On completion with word_valid_pad = 1 and ready_pad = 0: the candidate is dropped, word_pad is unchanged and ovf_pad <= 1.
REQ-026 On a transfer without completion, word_valid_pad <= 0.
REQ-027 ovf_pad stays 1 until clr_pad or reset.
REQ-028 clr_pad = 1 overrides the write: mask, cnt, word_valid_pad and ovf_pad become 0; bits_pad and word_pad are unchanged.
REQ-029 Switching auto_pad mid-word preserves the mask; completion still requires all eight indices to be written.

Reset
REQ-030 rstn_pad = 0 immediately, without waiting for a clock, forces bits_pad, word_pad, mask_pad, cnt_pad, word_valid_pad and ovf_pad to 0.
REQ-031 A reset asserted mid-word discards the partial word; the first write after release starts a new word at cnt = 0.
REQ-032 Inputs are ignored while rstn_pad = 0; normal operation resumes on the first rising edge after release.

Verification
REQ-033 Auto mode, DATA_INV = 0, 8 strobed writes of din = 1,0,1,1,0,0,1,0 (index 0..7), ready = 1 -> word_pad = 0x4D with word_valid_pad = 1 for one cycle, cnt_pad = 0, mask_pad = 0.
REQ-034 Manual mode, sel_pad = 7,6,...,0 with din = 1 each, then ready held at 0 -> word_pad = 0xFF held stable with word_valid_pad = 1; a second full word sets ovf_pad = 1 and word_pad stays 0xFF.
REQ-035 Writes to index 3 three times, then the remaining seven indices -> exactly one completion, on the 10th write; a strobe_n_pad = 1 cycle in between changes nothing.
REQ-036 Completion coincident with a transfer of the previous word -> word_valid_pad stays 1, word_pad updates, ovf_pad stays 0.
REQ-037 Asynchronous reset asserted between edges after 5 auto writes -> all outputs 0 before the next edge; after release, 8 writes are needed for the next completion.
REQ-038 DATA_INV = 1, auto mode, din all 0 for 8 writes -> word_pad = 0xFF; clr_pad asserted together with the 8th write -> no completion, mask_pad = 0, cnt_pad = 0.
